// File: rtl/drive_cmd_uart_tx.sv
// Drive command -> Create "Drive Direct" packet over 8N1 UART, preceded by Start/Full after reset.
// Start bit 1 cycle after accept, 50 bit-times per packet; cmd_ready low (command held off) during init/packet.
module drive_cmd_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int SLOW_MMPS    = 100,
   parameter int MEDIUM_MMPS  = 200,
   parameter int FAST_MMPS    = 300,
   parameter int TURN_MMPS    = 100,
   parameter int SKIP_REPEAT  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] cmd,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic       uart_tx,
   output logic       busy,
   output logic [2:0] last_cmd
);

   typedef enum logic [1:0] {INIT_PEND, INIT, IDLE, SEND} state_t;

   localparam logic [15:0] SLOW_V   = 16'(SLOW_MMPS);
   localparam logic [15:0] MEDIUM_V = 16'(MEDIUM_MMPS);
   localparam logic [15:0] FAST_V   = 16'(FAST_MMPS);
   localparam logic [15:0] TURN_V   = 16'(TURN_MMPS);
   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state;
   logic        active;
   logic [15:0] bit_cnt;
   logic [3:0]  bit_pos;
   logic [2:0]  byte_idx;
   logic [7:0]  shreg;

   logic [2:0]  sel_idx;
   logic [2:0]  mapped;
   logic [15:0] r_vel;
   logic [15:0] l_vel;
   logic [7:0]  tx_byte;
   logic        last_byte;

   // The serialiser looks one byte ahead once a frame is active so bytes chain with no gap.
   always_comb begin
      sel_idx   = active ? byte_idx + 3'd1 : byte_idx;
      mapped    = (cmd[2:1] == 2'b11) ? 3'b000 : cmd;
      r_vel     = 16'h0000;
      l_vel     = 16'h0000;
      case (last_cmd)
         3'b001: begin r_vel = TURN_V;        l_vel = 16'h0000 - TURN_V; end
         3'b010: begin r_vel = 16'h0000 - TURN_V; l_vel = TURN_V;     end
         3'b011: begin r_vel = SLOW_V;        l_vel = SLOW_V;           end
         3'b100: begin r_vel = MEDIUM_V;      l_vel = MEDIUM_V;         end
         3'b101: begin r_vel = FAST_V;        l_vel = FAST_V;           end
         default: begin r_vel = 16'h0000;     l_vel = 16'h0000;         end
      endcase
      tx_byte   = 8'h00;
      last_byte = 1'b0;
      if (state == INIT) begin
         tx_byte   = (sel_idx == 3'd0) ? 8'h80 : 8'h84;
         last_byte = (byte_idx == 3'd1);
      end else begin
         case (sel_idx)
            3'd0:    tx_byte = 8'h91;
            3'd1:    tx_byte = r_vel[15:8];
            3'd2:    tx_byte = r_vel[7:0];
            3'd3:    tx_byte = l_vel[15:8];
            default: tx_byte = l_vel[7:0];
         endcase
         last_byte = (byte_idx == 3'd4);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT_PEND;
         uart_tx   <= 1'b1;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         last_cmd  <= 3'b000;
         active    <= 1'b0;
         bit_cnt   <= 16'd0;
         bit_pos   <= 4'd0;
         byte_idx  <= 3'd0;
         shreg     <= 8'h00;
      end else begin
         case (state)
            INIT_PEND: begin
               state    <= INIT;
               busy     <= 1'b1;
               active   <= 1'b0;
               byte_idx <= 3'd0;
            end
            IDLE: begin
               if (cmd_valid && cmd_ready &&
                   !((SKIP_REPEAT != 0) && (mapped == last_cmd))) begin
                  last_cmd  <= mapped;
                  state     <= SEND;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  active    <= 1'b0;
                  byte_idx  <= 3'd0;
               end
            end
            default: begin
               if (!active) begin
                  shreg   <= tx_byte;
                  uart_tx <= 1'b0;
                  active  <= 1'b1;
                  bit_cnt <= 16'd0;
                  bit_pos <= 4'd0;
               end else if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= 16'd0;
                  if (bit_pos == 4'd9) begin
                     if (last_byte) begin
                        active    <= 1'b0;
                        uart_tx   <= 1'b1;
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                     end else begin
                        byte_idx <= byte_idx + 3'd1;
                        shreg    <= tx_byte;
                        uart_tx  <= 1'b0;
                        bit_pos  <= 4'd0;
                     end
                  end else begin
                     bit_pos <= bit_pos + 4'd1;
                     uart_tx <= (bit_pos == 4'd8) ? 1'b1 : shreg[bit_pos[2:0]];
                  end
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end
         endcase
      end
   end

endmodule
